// File: rtl/fp_unit_responder.sv
// Responder for the effects' float request handshake: dispatches one op at a time to the float cores, compares internally.
// Optional sticky illegal-opcode flag under FP_RESPONDER_ILLEGAL_OP_EN; default build ties illegal_op low.
module fp_unit_responder #(
  parameter int ADDSUB_LATENCY = 7,
  parameter int MUL_LATENCY    = 5,
  parameter int ITOF_LATENCY   = 6,
  parameter int FTOI_LATENCY   = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_en,
  input  logic [31:0] dataa,
  input  logic [31:0] datab,
  input  logic [2:0]  operation,
  output logic        done,
  output logic [31:0] result,
  output logic [31:0] core_dataa,
  output logic [31:0] core_datab,
  output logic        addsub_en,
  output logic        mul_en,
  output logic        itof_en,
  output logic        ftoi_en,
  output logic        addsub_add,
  input  logic [31:0] addsub_result,
  input  logic [31:0] mul_result,
  input  logic [31:0] itof_result,
  input  logic [31:0] ftoi_result,
  output logic        illegal_op
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE, S_RELEASE} state_t;

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic [2:0]  r_op;
  logic        r_done;
  logic [31:0] r_result;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic        r_addsub_en;
  logic        r_mul_en;
  logic        r_itof_en;
  logic        r_ftoi_en;
  logic        r_addsub_add;

  logic [31:0] w_cmp;
  logic [31:0] w_sel;
  logic [7:0]  w_lat;
  logic        w_a_nan;
  logic        w_b_nan;
  logic        w_mag_lt;

  always_comb begin
    w_lat = 8'd0;
    case (operation)
      3'd0, 3'd1: w_lat = 8'(ADDSUB_LATENCY);
      3'd3:       w_lat = 8'(MUL_LATENCY);
      3'd4:       w_lat = 8'(FTOI_LATENCY);
      3'd5:       w_lat = 8'(ITOF_LATENCY);
      3'd6:       w_lat = 8'd1;
      default:    w_lat = 8'd0;
    endcase
  end

  assign w_a_nan  = (&r_a[30:23]) && (|r_a[22:0]);
  assign w_b_nan  = (&r_b[30:23]) && (|r_b[22:0]);
  assign w_mag_lt = r_a[30:0] < r_b[30:0];

  // Sign-magnitude ordering; two negatives invert the magnitude comparison.
  always_comb begin
    w_cmp = 32'd0;
    if (w_a_nan || w_b_nan)
      w_cmp = 32'd0;
    else if ((r_a[30:0] == 31'd0 && r_b[30:0] == 31'd0) || r_a == r_b)
      w_cmp = 32'd1;
    else if (r_a[31] != r_b[31])
      w_cmp = r_a[31] ? 32'd4 : 32'd2;
    else if (!r_a[31])
      w_cmp = w_mag_lt ? 32'd4 : 32'd2;
    else
      w_cmp = w_mag_lt ? 32'd2 : 32'd4;
  end

  always_comb begin
    w_sel = 32'd0;
    case (r_op)
      3'd0, 3'd1: w_sel = addsub_result;
      3'd3:       w_sel = mul_result;
      3'd4:       w_sel = ftoi_result;
      3'd5:       w_sel = itof_result;
      3'd6:       w_sel = w_cmp;
      default:    w_sel = 32'd0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= 8'd0;
      r_op         <= 3'd0;
      r_done       <= 1'b0;
      r_result     <= 32'd0;
      r_a          <= 32'd0;
      r_b          <= 32'd0;
      r_addsub_en  <= 1'b0;
      r_mul_en     <= 1'b0;
      r_itof_en    <= 1'b0;
      r_ftoi_en    <= 1'b0;
      r_addsub_add <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (clk_en) begin
            r_a          <= dataa;
            r_b          <= datab;
            r_op         <= operation;
            r_cnt        <= w_lat;
            r_addsub_add <= (operation == 3'd1);
            r_addsub_en  <= (operation == 3'd0) || (operation == 3'd1);
            r_mul_en     <= (operation == 3'd3);
            r_ftoi_en    <= (operation == 3'd4);
            r_itof_en    <= (operation == 3'd5);
            r_state      <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (!clk_en) begin
            r_addsub_en <= 1'b0;
            r_mul_en    <= 1'b0;
            r_itof_en   <= 1'b0;
            r_ftoi_en   <= 1'b0;
            r_state     <= S_IDLE;
          end else if (r_cnt == 8'd0) begin
            r_result <= w_sel;
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end else begin
            r_cnt <= r_cnt - 8'd1;
            // Enables drop on the edge that takes the count to zero: exactly L enabled edges.
            if (r_cnt == 8'd1) begin
              r_addsub_en <= 1'b0;
              r_mul_en    <= 1'b0;
              r_itof_en   <= 1'b0;
              r_ftoi_en   <= 1'b0;
            end
          end
        end
        S_DONE:    r_state <= clk_en ? S_RELEASE : S_IDLE;
        S_RELEASE: if (!clk_en) r_state <= S_IDLE;
        default:   r_state <= S_IDLE;
      endcase
    end
  end

`ifdef FP_RESPONDER_ILLEGAL_OP_EN
  logic r_illegal;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_illegal <= 1'b0;
    else if (r_state == S_IDLE && clk_en && (operation == 3'd2 || operation == 3'd7))
      r_illegal <= 1'b1;
  end
  assign illegal_op = r_illegal;
`else
  assign illegal_op = 1'b0;
`endif

  assign done       = r_done;
  assign result     = r_result;
  assign core_dataa = r_a;
  assign core_datab = r_b;
  assign addsub_en  = r_addsub_en;
  assign mul_en     = r_mul_en;
  assign itof_en    = r_itof_en;
  assign ftoi_en    = r_ftoi_en;
  assign addsub_add = r_addsub_add;

endmodule

// File: doc/fp_unit_responder.md
# fp_unit_responder

Responder side of the effects' floating-point request handshake (`fp_clk_en` / `fp_dataa` / `fp_datab` / `fp_operation` → `fp_done` / `fp_result`). It accepts one operation at a time from an effect block and dispatches it to the pipelined float cores: add/sub, mul, int→float and float→int. It runs each core for that core's fixed latency, computes compares internally, and returns a one-cycle `done` with a held result. It sits between the effect chain arbiter and the float core instances.

## Interface
Parameters:
- ADDSUB_LATENCY, 7, add/sub core pipeline depth (≥1)
- MUL_LATENCY, 5, mul core pipeline depth (≥1)
- ITOF_LATENCY, 6, int→float core depth (≥1)
- FTOI_LATENCY, 6, float→int core depth (≥1)

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- clk_en  in  1  request; held high by requester until it sees done
- dataa  in  32  operand A (IEEE single or int32)
- datab  in  32  operand B
- operation  in  3  0 sub, 1 add, 3 mul, 4 float→int, 5 int→float, 6 compare; 2 and 7 are illegal
- done  out  1  one-cycle completion pulse
- result  out  32  result, held until next completion
- core_dataa, core_datab  out  32  registered operands to cores
- addsub_en, mul_en, itof_en, ftoi_en  out  1  core clock enables
- addsub_add  out  1  1 = add, 0 = sub
- addsub_result, mul_result, itof_result, ftoi_result  in  32  core outputs
- illegal_op  out  1  sticky illegal-opcode flag (see Configuration)

## Operation
- States: IDLE, BUSY, DONE, RELEASE.
- IDLE, clk_en=1 at edge E0:
  - latch dataa/datab into core_dataa/core_datab, latch operation;
  - load counter with L; go BUSY.
  - L per op: addsub/mul/itof/ftoi = the matching parameter; compare = 1; illegal = 0.
- BUSY:
  - the selected core enable is high, all others low;
  - counter decrements each cycle;
  - at count 0, capture the selected source into result and go DONE.
- Illegal op: result = 0, no core enable.
- DONE: done=1 for exactly this cycle.
  - If clk_en=1, go RELEASE; else go IDLE.
- RELEASE: wait for clk_en=0, then go IDLE. This prevents re-triggering on a stale request.
- Compare (internal, on latched operands): result = {29'b0, less, greater, equal}.
  - 4 = A<B, 2 = A>B, 1 = equal.
  - +0 and −0 compare equal.
  - If either operand is NaN (exp=0xFF, mantissa≠0), result = 0.
  - Ordering is sign-magnitude: both negative inverts the magnitude order.
- Abort: clk_en=0 while BUSY → go IDLE next edge; enables drop, no done, result unchanged.

## Timing
- done rises L+1 edges after E0; result is valid on the same cycle and held afterwards.
  - add: done at E0+8; mul: E0+6; compare: E0+2; illegal: E0+1.
- Core enables are high for exactly L cycles, E0+1 through E0+L.
- Minimum back-to-back spacing: requester drops clk_en the cycle after done and re-raises it one cycle later. IDLE accepts immediately.
- Reset, asynchronous, any state:
  - state IDLE, counter 0;
  - done=0, result=0, core_dataa=core_datab=0;
  - all enables 0, addsub_add=0, illegal_op=0.
- Reset mid-operation discards the request; no done is issued.

## Configuration
- `FP_RESPONDER_ILLEGAL_OP_EN` defined:
  - illegal_op is set at the edge an opcode 2 or 7 is accepted;
  - it stays set until rst.
- Undefined: illegal_op is tied 0. Illegal-op completion (done at E0+1, result 0) is unchanged.

## Test plan
- Add: dataa=0x3F800000, datab=0x40000000, op=1; addsub_result model returns 0x40400000 → addsub_en high for 7 cycles, addsub_add=1, done at E0+8, result=0x40400000.
- Compare: A=0x3C2AAAAB, B=0x3DD55555, op=6 → done at E0+2, result=4. Swapped operands → 2. A=0x80000000, B=0 → 1. A=0x7FC00000 → 0.
- Handshake: clk_en held high 3 cycles past done → exactly one done pulse, state RELEASE. Drop then re-raise with op=3 → new mul completes at its E0+6.
- Abort and reset: clk_en dropped at E0+3 of add → no done, enables low next cycle. Separately, rst asserted mid-BUSY → all outputs 0 immediately.
- Illegal op 7 → done at E0+1, result 0, no enable. illegal_op=1 with macro defined, 0 without.
- Convert: op=5, dataa=0xFFFF8000 → itof_en for 6 cycles, result = itof_result. op=4 → ftoi_en path with done at E0+7.
